id_ex_ctrl_pipe: RTL and testbench

//  Registered decode stage for the pipelined OTTER core: decodes the IF/ID instruction into the
//  EX control bundle and holds it in the ID/EX register. Adds load-use hazard bubbling, branch

---
 rtl/id_ex_ctrl_if.sv | 51 +++++
 rtl/id_ex_ctrl_pipe.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_ctrl_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_ctrl_if.sv
// ID-to-EX control bundle: IF/ID inputs, stall/busy status
// and the registered EX control outputs.
interface id_ex_ctrl_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_flush;
    logic        stall_id;
    logic        md_busy;
    logic        ex_valid;
    logic        ex_illegal;
    logic        ex_RegWrite;
    logic        ex_MemWrite;
    logic        ex_MemSign;
    logic        ex_Jump;
    logic        ex_Branch;
    logic        ex_ALUSrc;
    logic        ex_muldiv;
    logic [1:0]  ex_ResultSrc;
    logic [1:0]  ex_MemSize;
    logic [4:0]  ex_ALUControl;
    logic [2:0]  ex_ImmSrc;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;

    modport slave (
        input  id_valid, id_instr, ex_flush,
        output stall_id, md_busy,
        output ex_valid, ex_illegal,
        output ex_RegWrite, ex_MemWrite,
        output ex_MemSign, ex_Jump,
        output ex_Branch, ex_ALUSrc,
        output ex_muldiv, ex_ResultSrc,
        output ex_MemSize, ex_ALUControl,
        output ex_ImmSrc,
        output ex_rd, ex_rs1, ex_rs2
    );

    modport master (
        output id_valid, id_instr, ex_flush,
        input  stall_id, md_busy,
        input  ex_valid, ex_illegal,
        input  ex_RegWrite, ex_MemWrite,
        input  ex_MemSign, ex_Jump,
        input  ex_Branch, ex_ALUSrc,
        input  ex_muldiv, ex_ResultSrc,
        input  ex_MemSize, ex_ALUControl,
        input  ex_ImmSrc,
        input  ex_rd, ex_rs1, ex_rs2
    );
endinterface

// File: rtl/id_ex_ctrl_pipe.sv
// OTTER decode stage: decodes IF/ID into the ID/EX control
// register with load-use bubbling, flush and MUL/DIV hold.
module id_ex_ctrl_pipe #(
    parameter int ENABLE_M   = 1,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 3
) (
    input logic         CLK,
    input logic         RST,
    id_ex_ctrl_if.slave bus
);
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       RegWrite;
        logic       MemWrite;
        logic       MemSign;
        logic       Jump;
        logic       Branch;
        logic       ALUSrc;
        logic       muldiv;
        logic [1:0] ResultSrc;
        logic [1:0] MemSize;
        logic [4:0] ALUControl;
        logic [2:0] ImmSrc;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    localparam bit M_ON = (ENABLE_M != 0);
    localparam logic [CNT_W-1:0] LOAD_CNT =
        CNT_W'(MD_LATENCY - 1);

    ctrl_t            r_ex;
    logic [CNT_W-1:0] r_cnt;

    ctrl_t      w_dec;
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic       w_md, w_lui, w_auipc, w_jal, w_jalr;
    logic       w_br, w_ld, w_st, w_opi, w_alu, w_mdok;
    logic       w_use1, w_use2, w_lu, w_hold;

    assign w_op   = bus.id_instr[6:0];
    assign w_f3   = bus.id_instr[14:12];
    assign w_md   = bus.id_instr[31:25] == 7'b0000001;
    assign w_lui  = w_op == 7'b0110111;
    assign w_auipc = w_op == 7'b0010111;
    assign w_jal  = w_op == 7'b1101111;
    assign w_jalr = w_op == 7'b1100111;
    assign w_br   = w_op == 7'b1100011;
    assign w_ld   = w_op == 7'b0000011;
    assign w_st   = w_op == 7'b0100011;
    assign w_opi  = w_op == 7'b0010011;
    assign w_alu  = (w_op == 7'b0110011) & !w_md;
    assign w_mdok = (w_op == 7'b0110011) & w_md & M_ON;

    assign w_use1 = !(w_lui | w_auipc | w_jal);
    assign w_use2 = (w_op == 7'b0110011) | w_st | w_br;

    always_comb begin
        w_dec            = '0;
        w_dec.valid      = 1'b1;
        w_dec.MemSign    = bus.id_instr[14];
        w_dec.MemSize    = bus.id_instr[13:12];
        w_dec.rd         = bus.id_instr[11:7];
        w_dec.rs1        = bus.id_instr[19:15];
        w_dec.rs2        = bus.id_instr[24:20];
        unique case (1'b1)
            w_lui: begin
                w_dec.RegWrite   = 1'b1;
                w_dec.ALUSrc     = 1'b1;
                w_dec.ImmSrc     = 3'd4;
                w_dec.ALUControl = 5'b01001;
            end
            w_auipc: begin
                w_dec.RegWrite  = 1'b1;
                w_dec.ResultSrc = 2'd2;
                w_dec.ImmSrc    = 3'd4;
            end
            w_jal: begin
                w_dec.RegWrite  = 1'b1;
                w_dec.Jump      = 1'b1;
                w_dec.ResultSrc = 2'd2;
                w_dec.ImmSrc    = 3'd5;
            end
            w_jalr: begin
                w_dec.RegWrite  = 1'b1;
                w_dec.Jump      = 1'b1;
                w_dec.ALUSrc    = 1'b1;
                w_dec.ResultSrc = 2'd2;
                w_dec.ImmSrc    = 3'd1;
            end
            w_br: begin
                w_dec.Branch     = 1'b1;
                w_dec.ImmSrc     = 3'd3;
                w_dec.ALUControl = {2'b10, w_f3};
            end
            w_ld: begin
                w_dec.RegWrite  = 1'b1;
                w_dec.ALUSrc    = 1'b1;
                w_dec.ResultSrc = 2'd1;
                w_dec.ImmSrc    = 3'd1;
            end
            w_st: begin
                w_dec.MemWrite = 1'b1;
                w_dec.ALUSrc   = 1'b1;
                w_dec.ImmSrc   = 3'd2;
            end
            w_opi: begin
                w_dec.RegWrite   = 1'b1;
                w_dec.ALUSrc     = 1'b1;
                w_dec.ImmSrc     = 3'd1;
                w_dec.ALUControl = {1'b0,
                    (w_f3 == 3'b101) & bus.id_instr[30],
                    w_f3};
            end
            w_alu: begin
                w_dec.RegWrite   = 1'b1;
                w_dec.ALUControl = {1'b0,
                    bus.id_instr[30], w_f3};
            end
            w_mdok: begin
                w_dec.RegWrite   = 1'b1;
                w_dec.muldiv     = 1'b1;
                w_dec.ALUControl = {2'b00, w_f3};
            end
            default: begin
                // Unsupported opcodes reach EX as inert markers
                w_dec         = '0;
                w_dec.valid   = 1'b1;
                w_dec.illegal = 1'b1;
                w_dec.rd      = bus.id_instr[11:7];
                w_dec.rs1     = bus.id_instr[19:15];
                w_dec.rs2     = bus.id_instr[24:20];
            end
        endcase
    end

    assign w_hold = r_cnt != '0;
    assign w_lu = r_ex.valid & (r_ex.ResultSrc == 2'd1)
        & (r_ex.rd != 5'd0) & bus.id_valid
        & ((w_use1 & (w_dec.rs1 == r_ex.rd))
         | (w_use2 & (w_dec.rs2 == r_ex.rd)));

    assign bus.stall_id = !bus.ex_flush & (w_hold | w_lu);
    assign bus.md_busy  = w_hold;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ex  <= '0;
            r_cnt <= '0;
        end else if (bus.ex_flush) begin
            r_ex  <= '0;
            r_cnt <= '0;
        end else if (w_hold) begin
            r_cnt <= r_cnt - 1'b1;
        end else if (w_lu | !bus.id_valid) begin
            r_ex <= '0;
        end else begin
            r_ex  <= w_dec;
            r_cnt <= w_dec.muldiv ? LOAD_CNT : '0;
        end
    end

    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_illegal    = r_ex.illegal;
    assign bus.ex_RegWrite   = r_ex.RegWrite;
    assign bus.ex_MemWrite   = r_ex.MemWrite;
    assign bus.ex_MemSign    = r_ex.MemSign;
    assign bus.ex_Jump       = r_ex.Jump;
    assign bus.ex_Branch     = r_ex.Branch;
    assign bus.ex_ALUSrc     = r_ex.ALUSrc;
    assign bus.ex_muldiv     = r_ex.muldiv;
    assign bus.ex_ResultSrc  = r_ex.ResultSrc;
    assign bus.ex_MemSize    = r_ex.MemSize;
    assign bus.ex_ALUControl = r_ex.ALUControl;
    assign bus.ex_ImmSrc     = r_ex.ImmSrc;
    assign bus.ex_rd         = r_ex.rd;
    assign bus.ex_rs1        = r_ex.rs1;
    assign bus.ex_rs2        = r_ex.rs2;
endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: decode table, hazard/hold
// sequences and random traffic against a cycle model.
module tb_id_ex_ctrl_pipe;
    localparam int MDL = 4;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       RegWrite;
        logic       MemWrite;
        logic       MemSign;
        logic       Jump;
        logic       Branch;
        logic       ALUSrc;
        logic       muldiv;
        logic [1:0] ResultSrc;
        logic [1:0] MemSize;
        logic [4:0] ALUControl;
        logic [2:0] ImmSrc;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_t;

    typedef struct {
        string       nm;
        logic [31:0] instr;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    ex_t  m_ent;
    int   m_age;

    always #5 clk = ~clk;

    id_ex_ctrl_if bus ();
    id_ex_ctrl_if bus0 ();

    assign bus0.id_valid = bus.id_valid;
    assign bus0.id_instr = bus.id_instr;
    assign bus0.ex_flush = bus.ex_flush;

    id_ex_ctrl_pipe #(.ENABLE_M(1), .MD_LATENCY(MDL),
        .CNT_W(3)) u_dut (
        .CLK(clk), .RST(rst), .bus(bus));

    id_ex_ctrl_pipe #(.ENABLE_M(0), .MD_LATENCY(MDL),
        .CNT_W(3)) u_dut0 (
        .CLK(clk), .RST(rst), .bus(bus0));

    task automatic cmp(input string nm,
        input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h",
                nm, a, e);
        end
    endtask

    function automatic ex_t dut_ex();
        ex_t a;
        a.valid      = bus.ex_valid;
        a.illegal    = bus.ex_illegal;
        a.RegWrite   = bus.ex_RegWrite;
        a.MemWrite   = bus.ex_MemWrite;
        a.MemSign    = bus.ex_MemSign;
        a.Jump       = bus.ex_Jump;
        a.Branch     = bus.ex_Branch;
        a.ALUSrc     = bus.ex_ALUSrc;
        a.muldiv     = bus.ex_muldiv;
        a.ResultSrc  = bus.ex_ResultSrc;
        a.MemSize    = bus.ex_MemSize;
        a.ALUControl = bus.ex_ALUControl;
        a.ImmSrc     = bus.ex_ImmSrc;
        a.rd         = bus.ex_rd;
        a.rs1        = bus.ex_rs1;
        a.rs2        = bus.ex_rs2;
        return a;
    endfunction

    function automatic ex_t ref_dec(input logic [31:0] i);
        ex_t e = '0;
        int  f3 = int'(i[14:12]);
        bit  bad = 0;
        e.valid   = 1;
        e.rd      = i[11:7];
        e.rs1     = i[19:15];
        e.rs2     = i[24:20];
        e.MemSign = i[14];
        e.MemSize = i[13:12];
        case (i[6:0])
            7'h37: begin
                e.RegWrite = 1; e.ALUSrc = 1;
                e.ImmSrc = 4; e.ALUControl = 9;
            end
            7'h17: begin
                e.RegWrite = 1; e.ResultSrc = 2;
                e.ImmSrc = 4;
            end
            7'h6F: begin
                e.RegWrite = 1; e.Jump = 1;
                e.ResultSrc = 2; e.ImmSrc = 5;
            end
            7'h67: begin
                e.RegWrite = 1; e.Jump = 1; e.ALUSrc = 1;
                e.ResultSrc = 2; e.ImmSrc = 1;
            end
            7'h63: begin
                e.Branch = 1; e.ImmSrc = 3;
                e.ALUControl = 5'(16 + f3);
            end
            7'h03: begin
                e.RegWrite = 1; e.ALUSrc = 1;
                e.ResultSrc = 1; e.ImmSrc = 1;
            end
            7'h23: begin
                e.MemWrite = 1; e.ALUSrc = 1; e.ImmSrc = 2;
            end
            7'h13: begin
                e.RegWrite = 1; e.ALUSrc = 1; e.ImmSrc = 1;
                e.ALUControl = 5'(f3
                    + ((f3 == 5 && i[30]) ? 8 : 0));
            end
            7'h33: begin
                e.RegWrite = 1;
                if (i[31:25] == 7'd1) begin
                    e.muldiv = 1;
                    e.ALUControl = 5'(f3);
                end else begin
                    e.ALUControl = 5'(f3 + (i[30] ? 8 : 0));
                end
            end
            default: bad = 1;
        endcase
        if (bad) begin
            e = '0; e.valid = 1; e.illegal = 1;
        end
        return e;
    endfunction

    task automatic cmp_ex(input string nm, input ex_t e);
        ex_t a = dut_ex();
        if (e.illegal)
            cmp(nm, 64'({a.valid, a.illegal, a.RegWrite,
                a.MemWrite, a.Branch, a.Jump}),
                64'({e.valid, e.illegal, e.RegWrite,
                e.MemWrite, e.Branch, e.Jump}));
        else
            cmp(nm, {28'd0, a}, {28'd0, e});
    endtask

    task automatic step(input logic r, input logic v,
        input logic [31:0] ins, input logic fl,
        output logic st, output logic bz);
        logic [6:0] op = ins[6:0];
        bit u1, u2, hold, lu;
        rst = r;
        bus.id_valid = v;
        bus.id_instr = ins;
        bus.ex_flush = fl;
        #1;
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = op == 7'h33 || op == 7'h23 || op == 7'h63;
        hold = m_ent.muldiv && m_age < MDL - 1;
        lu = m_ent.valid && m_ent.ResultSrc == 1
            && m_ent.rd != 0 && v
            && ((u1 && ins[19:15] == m_ent.rd)
             || (u2 && ins[24:20] == m_ent.rd));
        st = bus.stall_id;
        bz = bus.md_busy;
        cmp("stall_id", 64'(st), 64'(!fl && (hold || lu)));
        cmp("md_busy", 64'(bz), 64'(hold));
        @(posedge clk);
        if (r) begin
            m_ent = '0; m_age = 0;
        end else if (fl) begin
            m_ent = '0; m_age = 0;
        end else if (hold) begin
            m_age++;
        end else if (lu || !v) begin
            m_ent = '0;
        end else begin
            m_ent = ref_dec(ins); m_age = 0;
        end
        #1;
        cmp_ex("ex_bundle", m_ent);
    endtask

    function automatic logic [15:0] mk(input bit il,
        input bit rw, input bit mw, input bit br,
        input bit j, input bit src, input int res,
        input int imm, input int alu);
        return {il, rw, mw, br, j, src,
            2'(res), 3'(imm), 5'(alu)};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [12] = '{7'h37, 7'h17, 7'h6F,
            7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
            7'h33, 7'h0F, 7'h73};
        logic [31:0] i = $urandom;
        int k = $urandom_range(0, 11);
        i[6:0]   = ops[k];
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        if (ops[k] == 7'h33)
            case ($urandom_range(0, 2))
                0: i[31:25] = 7'h00;
                1: i[31:25] = 7'h20;
                default: i[31:25] = 7'h01;
            endcase
        return i;
    endfunction

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h00012283;
    localparam logic [31:0] ADD  = 32'h00128333;
    localparam logic [31:0] MUL  = 32'h022081B3;

    initial begin
        vec_t tbl [$];
        logic st, bz, hold_st;
        int   nmd, nst;
        ex_t  a;
        logic [31:0] ri;

        rst = 1'b1;
        bus.id_valid = 1'b0;
        bus.id_instr = '0;
        bus.ex_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_ent = '0;
        m_age = 0;
        cmp("rst_ex", {28'd0, dut_ex()}, 64'd0);
        cmp("rst_stall", 64'(bus.stall_id), 64'd0);
        cmp("rst_busy", 64'(bus.md_busy), 64'd0);

        tbl.push_back('{"addi", ADDI, mk(0,1,0,0,0,1,0,1,0)});
        tbl.push_back('{"srai", 32'h4030D113,
            mk(0,1,0,0,0,1,0,1,13)});
        tbl.push_back('{"sub", 32'h402081B3,
            mk(0,1,0,0,0,0,0,0,8)});
        tbl.push_back('{"add", ADD, mk(0,1,0,0,0,0,0,0,0)});
        tbl.push_back('{"lw", LW, mk(0,1,0,0,0,1,1,1,0)});
        tbl.push_back('{"sw", 32'h00512223,
            mk(0,0,1,0,0,1,0,2,0)});
        tbl.push_back('{"beq", 32'h00208463,
            mk(0,0,0,1,0,0,0,3,16)});
        tbl.push_back('{"bne", 32'h00209463,
            mk(0,0,0,1,0,0,0,3,17)});
        tbl.push_back('{"lui", 32'h123453B7,
            mk(0,1,0,0,0,1,0,4,9)});
        tbl.push_back('{"auipc", 32'h00001417,
            mk(0,1,0,0,0,0,2,4,0)});
        tbl.push_back('{"jal", 32'h010000EF,
            mk(0,1,0,0,1,0,2,5,0)});
        tbl.push_back('{"jalr_x0", 32'h00008067,
            mk(0,1,0,0,1,1,2,1,0)});
        tbl.push_back('{"fence", 32'h0000000F,
            mk(1,0,0,0,0,0,0,0,0)});
        tbl.push_back('{"ecall", 32'h00000073,
            mk(1,0,0,0,0,0,0,0,0)});

        foreach (tbl[n]) begin
            step(0, 1, tbl[n].instr, 0, st, bz);
            cmp({tbl[n].nm, "_stall"}, 64'(st), 64'd0);
            a = dut_ex();
            cmp({tbl[n].nm, "_valid"}, 64'(a.valid), 64'd1);
            if (tbl[n].exp[15])
                cmp(tbl[n].nm, 64'({a.illegal, a.RegWrite,
                    a.MemWrite, a.Branch, a.Jump}),
                    64'(tbl[n].exp[15:11]));
            else
                cmp(tbl[n].nm, 64'({a.illegal, a.RegWrite,
                    a.MemWrite, a.Branch, a.Jump, a.ALUSrc,
                    a.ResultSrc, a.ImmSrc, a.ALUControl}),
                    64'(tbl[n].exp));
            step(0, 0, '0, 0, st, bz);
        end

        // load-use: one bubble, then ADD enters EX
        step(0, 1, LW, 0, st, bz);
        step(0, 1, ADD, 0, st, bz);
        cmp("lu_stall", 64'(st), 64'd1);
        cmp("lu_bubble", 64'(bus.ex_valid), 64'd0);
        step(0, 1, ADD, 0, st, bz);
        cmp("lu_release", 64'(st), 64'd0);
        cmp("lu_add_rd", 64'({bus.ex_valid, bus.ex_rd}),
            64'({1'b1, 5'd6}));

        // MUL residency and ENABLE_M=0 flagging
        step(0, 0, '0, 0, st, bz);
        step(0, 1, MUL, 0, st, bz);
        cmp("m0_illegal", 64'({bus0.ex_valid,
            bus0.ex_illegal, bus0.ex_RegWrite,
            bus0.ex_MemWrite, bus0.md_busy}),
            64'(5'b11000));
        nmd = int'(bus.ex_muldiv);
        nst = 0;
        for (int k = 0; k < 5; k++) begin
            step(0, 1, ADDI, 0, st, bz);
            nmd += int'(bus.ex_muldiv);
            nst += int'(st);
        end
        cmp("mul_resident", 64'(nmd), 64'(MDL));
        cmp("mul_stalls", 64'(nst), 64'(MDL - 1));

        // flush during MUL hold
        step(0, 1, MUL, 0, st, bz);
        step(0, 1, ADDI, 0, hold_st, bz);
        step(0, 1, ADDI, 1, st, bz);
        cmp("fl_hold_was", 64'(hold_st), 64'd1);
        cmp("fl_hold_stall", 64'(st), 64'd0);
        cmp("fl_hold_ex", 64'({bus.ex_valid, bus.md_busy,
            bus.stall_id}), 64'd0);

        // flush during load-use
        step(0, 1, LW, 0, st, bz);
        step(0, 1, ADD, 1, st, bz);
        cmp("fl_lu_stall", 64'(st), 64'd0);
        cmp("fl_lu_ex", 64'(bus.ex_valid), 64'd0);

        // reset mid MUL hold
        step(0, 1, MUL, 0, st, bz);
        step(0, 1, ADDI, 0, st, bz);
        step(1, 1, ADDI, 0, st, bz);
        cmp("rst_mul_ex", {28'd0, dut_ex()}, 64'd0);
        cmp("rst_mul_st", 64'({bus.md_busy, bus.stall_id}),
            64'd0);

        st = 1'b0;
        ri = rnd_instr();
        for (int k = 0; k < 3000; k++) begin
            if (!st) ri = rnd_instr();
            step($urandom_range(0, 99) < 2,
                $urandom_range(0, 9) != 0, ri,
                $urandom_range(0, 9) == 0, st, bz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
